display_mux_scan: RTL
=====================

Name: display_mux_scan

Overview:
- Parametrised successor to the vending-machine 4-digit display driver.
- Time-multiplexes NUM_DIGITS 4-bit glyph codes onto one shared code bus plus one-hot digit enables, using a programmable dwell prescaler.
- Adds tear-free double-buffered message loading with an acknowledge, per-digit blink, leading-zero blanking and an anti-ghosting guard interval.
- Sits between the vending FSM (message source) and the existing 4-bit-to-7-segment decoder (consumes code_out).

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
PRESCALE, 50000, clk cycles each digit is selected (dwell); >= GUARD+2
GUARD, 2, cycles at start of each dwell with all digit enables off (0 disables guard)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)
BLANK_CODE, 4'b1111, glyph code the decoder renders as all segments off

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  single-cycle request to replace the displayed message
msg_in  in  4*NUM_DIGITS  message; bits [3:0] = leftmost digit (index 0)
blink_en  in  1  global blink enable
blink_mask  in  NUM_DIGITS  bit i=1: digit i blinks when blink_en=1
lz_blank  in  1  leading-zero blanking enable
dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high, bit i = digit i
code_out  out  4  glyph code for the currently selected digit
load_ack  out  1  one-cycle pulse when a message is committed to the display
frame_tick  out  1  one-cycle pulse on the last cycle of each full scan frame

Behaviour:
- Reset (rst=1 at a clk edge): prescale counter=0, digit index=0, active and shadow buffers all BLANK_CODE, pending=0, frame counter=0, blink phase=0. Outputs: dig_sel=0, code_out=BLANK_CODE, load_ack=0, frame_tick=0. Reset mid-frame or with a pending load discards the pending load; no ack is issued.
- Scan:
  - Prescale counter runs 0..PRESCALE-1 and wraps.
  - The digit index advances on the wrap, cycling 0..NUM_DIGITS-1 and wrapping to 0.
  - Frame end = prescale at PRESCALE-1 and index at NUM_DIGITS-1.
- Outputs are registered with 1-cycle latency from the internal counters:
  - dig_sel has bit[index] set only while prescale >= GUARD; otherwise all zero.
  - code_out = displayed code of the current index throughout the dwell, guard included.
- Displayed code for digit i, first match wins:
  1. blink_en=1, blink_mask[i]=1, blink phase=1 -> BLANK_CODE.
  2. lz_blank=1, i < NUM_DIGITS-1, and active codes 0..i all equal 4'b0000 -> BLANK_CODE. The last digit is never zero-blanked.
  3. Otherwise -> active code i.
- Blink:
  - Frame counter counts frame ends 0..BLINK_FRAMES-1.
  - On wrap, blink phase toggles.
  - Phase runs whether or not blink_en is set; blink_en only gates the blanking.
- Double-buffered load:
  - load=1 copies msg_in into shadow and sets pending.
  - At frame end with pending=1: active <= shadow, pending <= 0, load_ack=1 on the next cycle.
  - Load while pending: shadow overwritten, last load wins, only one ack.
  - Load on the frame-end cycle itself: msg_in commits directly to active in that cycle, pending cleared, ack issued.
  - The active buffer never changes except at a frame end, so there is no tearing.
- frame_tick is registered and coincides with load_ack when a commit occurs.
- All counter widths are sized with clog2 of their range; no overflow beyond the defined wraps.

Test Plan:
Parameters for all cases: NUM_DIGITS=4, PRESCALE=4, GUARD=1, BLINK_FRAMES=2.
1. Reset then run 20 cycles -> dig_sel 0000 on the first cycle of each dwell, then 0001 for 3 cycles, 0010, 0100, 1000, repeating; code_out=4'hF throughout; frame_tick every 16 cycles.
2. load with msg_in=16'h9_7_A_0 (digits O,P,E,n) mid-frame -> display unchanged until frame end; load_ack pulses once together with frame_tick; next frame code_out sequence 0,A,7,9.
3. Two loads in one frame (16'h4047 then 16'h5047) -> single ack; the frame after shows 7,4,0,5.
4. Load on the frame-end cycle -> commits in that same frame boundary; ack on the next cycle; new codes shown from digit 0 of the next frame.
5. Active 16'h5000, lz_blank=1 -> codes F,F,F,5. Active 16'h0000, lz_blank=1 -> F,F,F,0.
6. blink_en=1, blink_mask=4'b0011 -> digits 0 and 1 show F for frames 2-3, 6-7, ..., real codes otherwise. Assert rst during a pending load -> no ack; all outputs return to reset values next cycle.

Source files
------------

// File: rtl/display_mux_scan_if.sv
// Bundles the message-source and decoder-side signals of the display scanner.
// The master modport belongs to the message source. The slave modport belongs to the scanner.
`timescale 1ns/1ps

interface display_mux_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   msg_in;
  logic                      blink_en;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      lz_blank;
  logic [NUM_DIGITS-1:0]     dig_sel;
  logic [3:0]                code_out;
  logic                      load_ack;
  logic                      frame_tick;

  modport master (
    output load, msg_in, blink_en, blink_mask, lz_blank,
    input  dig_sel, code_out, load_ack, frame_tick
  );

  modport slave (
    input  load, msg_in, blink_en, blink_mask, lz_blank,
    output dig_sel, code_out, load_ack, frame_tick
  );
endinterface

// File: rtl/display_mux_scan.sv
// Multiplexed digit scanner for the vending-machine display.
// Messages are double-buffered and change only at frame boundaries.
// Supports per-digit blink, leading-zero blanking and a guard interval between digits.
`timescale 1ns/1ps

module display_mux_scan #(
  parameter int         NUM_DIGITS   = 4,
  parameter int         PRESCALE     = 50000,
  parameter int         GUARD        = 2,
  parameter int         BLINK_FRAMES = 64,
  parameter logic [3:0] BLANK_CODE   = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  display_mux_scan_if.slave  bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{BLANK_CODE}};

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    blink_q, blink_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic [3:0]              code_q, code_d;
  logic                    ack_q, ack_d;
  logic                    tick_q, tick_d;

  logic                    presc_wrap;
  logic                    frame_end;
  logic                    zero_run;
  logic                    lz_hit;
  logic                    blink_hit;
  logic [3:0]              cur_code;

  // Scan counters, blink phase and the double-buffered message commit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    presc_wrap  = (presc_q == PRESC_LAST);
    frame_end   = presc_wrap && (idx_q == IDX_LAST);
    presc_d     = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    pending_d   = pending_q;

    if (presc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (frame_end) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    if (bus.load) begin
      shadow_d = bus.msg_in;
    end

    // A load that lands on the frame-end cycle bypasses the shadow buffer.
    // It commits at this same boundary.
    if (frame_end) begin
      pending_d = 1'b0;
      if (bus.load) begin
        active_d = bus.msg_in;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    ack_d  = frame_end && (bus.load || pending_q);
    tick_d = frame_end;
  end

  // Select the current digit's code and compute its blink and leading-zero blanking conditions.
  always_comb begin
    zero_run  = 1'b1;
    lz_hit    = 1'b0;
    blink_hit = 1'b0;
    cur_code  = active_q[3:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run && (active_q[4*i +: 4] == 4'b0000);
      if (idx_q == IW'(i)) begin
        cur_code  = active_q[4*i +: 4];
        lz_hit    = zero_run && (i < NUM_DIGITS - 1);
        blink_hit = bus.blink_mask[i];
      end
    end
  end

  // Registered digit-enable and code outputs; enables stay dark during the guard interval.
  always_comb begin
    dig_sel_d = '0;
    if (presc_q >= GUARD_END) begin
      dig_sel_d[idx_q] = 1'b1;
    end
    if (bus.blink_en && blink_hit && blink_q) begin
      code_d = BLANK_CODE;
    end else if (bus.lz_blank && lz_hit) begin
      code_d = BLANK_CODE;
    end else begin
      code_d = cur_code;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      // NOTE: the message buffers are reset because the display must come up blank rather than show garbage.
      active_q    <= ALL_BLANK;
      shadow_q    <= ALL_BLANK;
      pending_q   <= 1'b0;
      dig_sel_q   <= '0;
      code_q      <= BLANK_CODE;
      ack_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      dig_sel_q   <= dig_sel_d;
      code_q      <= code_d;
      ack_q       <= ack_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.dig_sel    = dig_sel_q;
  assign bus.code_out   = code_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_tick = tick_q;

endmodule
